// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : default 640x480@60 timing constants and coordinate type.
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int COORD_W      = 11;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// vga_axis_counter : one timing axis; wrapping counter with registered
// active-area and sync-window flags aligned to the count.
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL_DEF,
  parameter int ACTIVE     = H_ACTIVE_DEF,
  parameter int SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
  parameter int SYNC_LEN   = H_SYNC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [COORD_W-1:0] count,
  output logic               active,
  output logic               in_sync,
  output logic               wrap
);

  localparam coord_t LAST     = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END  = coord_t'(ACTIVE);
  localparam coord_t SYNC_BEG = coord_t'(SYNC_START);
  localparam coord_t SYNC_END = coord_t'(SYNC_START + SYNC_LEN);

  coord_t next_count;

  assign wrap = (count == LAST);

  always_comb begin
    next_count = wrap ? '0 : count + coord_t'(1);
  end

  // Flags are computed from the next count so they land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= LAST;
      active  <= 1'b0;
      in_sync <= 1'b0;
    end else if (step) begin
      count   <= next_count;
      active  <= (next_count < ACT_END);
      in_sync <= (next_count >= SYNC_BEG) && (next_count < SYNC_END);
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// vga_sync_gen : VGA raster timing generator (x/y, enable, hsync/vsync,
// frame_start). Macro VGA_PIX_DIV4_EN selects an internal clk/4 pixel enable.
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               enable,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic step;
  logic h_active, h_in_sync, h_wrap;
  logic v_active, v_in_sync, v_wrap;

`ifdef VGA_PIX_DIV4_EN
  logic [1:0] prescale;
  logic       unused_pix_ce;

  assign unused_pix_ce = pix_ce;
  assign step          = (prescale == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= 2'd0;
    end else begin
      prescale <= prescale + 2'd1;
    end
  end
`else
  assign step = pix_ce;
`endif

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .count   (x),
    .active  (h_active),
    .in_sync (h_in_sync),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .step    (step & h_wrap),
    .count   (y),
    .active  (v_active),
    .in_sync (v_in_sync),
    .wrap    (v_wrap)
  );

  assign enable = h_active & v_active;
  assign hsync  = h_in_sync ? SYNC_POL : ~SYNC_POL;
  assign vsync  = v_in_sync ? SYNC_POL : ~SYNC_POL;

  // Set on the edge that loads (0,0); cleared on any other edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= step & h_wrap & v_wrap;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// tb_vga_sync_gen : bench for vga_sync_gen; default 640x480 instance plus a
// small-raster instance with positive sync, both checked against a frame model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

`ifdef VGA_PIX_DIV4_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  localparam int HA_A = 640, HF_A = 16, HS_A = 96, HB_A = 48;
  localparam int VA_A = 480, VF_A = 10, VS_A = 2,  VB_A = 33;
  localparam int TOT_A = (HA_A + HF_A + HS_A + HB_A) * (VA_A + VF_A + VS_A + VB_A);

  localparam int HA_B = 16, HF_B = 2, HS_B = 4, HB_B = 3;
  localparam int VA_B = 8,  VF_B = 2, VS_B = 2, VB_B = 3;
  localparam int HT_B  = HA_B + HF_B + HS_B + HB_B;
  localparam int TOT_B = HT_B * (VA_B + VF_B + VS_B + VB_B);

  localparam logic [25:0] RST_A   = {11'd799, 11'd524, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [25:0] FIRST_A = {11'd0,   11'd0,   1'b1, 1'b1, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] x_a, y_a, x_b, y_b;
  logic en_a, hs_a, vs_a, fs_a, en_b, hs_b, vs_b, fs_b;

  vga_sync_gen u_dut_a (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x_a), .y(y_a),
    .enable(en_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x_b), .y(y_b),
    .enable(en_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
  );

  // Frame model: a linear pixel index per instance, decoded into outputs.
  int pos_a = TOT_A - 1;
  int pos_b = TOT_B - 1;
  bit fs_ma = 1'b0;
  bit fs_mb = 1'b0;
  int pre   = 0;
  wire model_step;

`ifdef VGA_PIX_DIV4_EN
  assign model_step = (pre == 3);
`else
  assign model_step = pix_ce;
`endif

  always @(posedge clk) begin
    if (rst) begin
      pos_a <= TOT_A - 1;
      pos_b <= TOT_B - 1;
      fs_ma <= 1'b0;
      fs_mb <= 1'b0;
      pre   <= 0;
    end else begin
      pre <= (pre + 1) % 4;
      if (model_step) begin
        pos_a <= (pos_a + 1) % TOT_A;
        pos_b <= (pos_b + 1) % TOT_B;
        fs_ma <= ((pos_a + 1) % TOT_A) == 0;
        fs_mb <= ((pos_b + 1) % TOT_B) == 0;
      end else begin
        fs_ma <= 1'b0;
        fs_mb <= 1'b0;
      end
    end
  end

  function automatic logic [25:0] model_out(input int pos, input int ha, input int hf,
      input int hs, input int hb, input int va, input int vf, input int vs,
      input bit pol, input bit fs);
    int ht, px, py;
    logic en, h, v;
    ht = ha + hf + hs + hb;
    px = pos % ht;
    py = pos / ht;
    en = (px < ha) && (py < va);
    h  = (px >= ha + hf && px < ha + hf + hs) ? pol : !pol;
    v  = (py >= va + vf && py < va + vf + vs) ? pol : !pol;
    return {px[10:0], py[10:0], en, h, v, fs};
  endfunction

  wire [25:0] exp_a = model_out(pos_a, HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, 1'b0, fs_ma);
  wire [25:0] exp_b = model_out(pos_b, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, 1'b1, fs_mb);
  wire [25:0] obs_a = {x_a, y_a, en_a, hs_a, vs_a, fs_a};
  wire [25:0] obs_b = {x_b, y_b, en_b, hs_b, vs_b, fs_b};

  int checks = 0;
  int errors = 0;

  task automatic test_reset();
    rst = 1'b1;
    pix_ce = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_a !== RST_A) begin
      errors++; $display("FAIL reset_a actual=%h required=%h", obs_a, RST_A);
    end
    checks++;
    if (obs_b !== exp_b) begin
      errors++; $display("FAIL reset_b actual=%h required=%h", obs_b, exp_b);
    end
    rst = 1'b0;
`ifdef VGA_PIX_DIV4_EN
    pix_ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== RST_A) begin
        errors++; $display("FAIL div4_hold cyc=%0d actual=%h required=%h", i, obs_a, RST_A);
      end
    end
`endif
    @(negedge clk);
    checks++;
    if (obs_a !== FIRST_A) begin
      errors++; $display("FAIL first_pixel_a actual=%h required=%h", obs_a, FIRST_A);
    end
    checks++;
    if (obs_b !== exp_b) begin
      errors++; $display("FAIL first_pixel_b actual=%h required=%h", obs_b, exp_b);
    end
    pix_ce = 1'b1;
    @(negedge clk);
    checks++;
    if (fs_a !== 1'b0) begin
      errors++; $display("FAIL fs_width actual=%b required=0", fs_a);
    end
  endtask

  task automatic test_line();
    int hs_cnt = 0;
    int en_fall_x = -1;
    logic prev_en = en_a;
    logic [10:0] prev_x = x_a;
    logic [10:0] prev_y = y_a;
    pix_ce = 1'b1;
    for (int i = 0; i < 800 * DIV; i++) begin
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL line_a cyc=%0d actual=%h required=%h", i, obs_a, exp_a);
      end
      if (hs_a == 1'b0) hs_cnt++;
      if (prev_en && !en_a) en_fall_x = int'(x_a);
      if (prev_x == 11'd799 && x_a != prev_x) begin
        checks++;
        if (x_a !== 11'd0 || y_a !== prev_y + 11'd1) begin
          errors++; $display("FAIL line_wrap actual=%0d,%0d required=0,%0d", x_a, y_a, prev_y + 11'd1);
        end
      end
      prev_en = en_a;
      prev_x  = x_a;
      prev_y  = y_a;
    end
    checks++;
    if (hs_cnt != 96 * DIV) begin
      errors++; $display("FAIL hsync_width actual=%0d required=%0d", hs_cnt, 96 * DIV);
    end
    checks++;
    if (en_fall_x != 640) begin
      errors++; $display("FAIL enable_fall actual=%0d required=640", en_fall_x);
    end
  endtask

  task automatic test_frame();
    int vs_cnt = 0, fs_cnt = 0, last_fs = -1, period = 0;
    pix_ce = 1'b1;
    for (int i = 0; i < 2 * TOT_B * DIV; i++) begin
      @(negedge clk);
      checks++;
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL frame_b cyc=%0d actual=%h required=%h", i, obs_b, exp_b);
      end
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL frame_a cyc=%0d actual=%h required=%h", i, obs_a, exp_a);
      end
      if (vs_b == 1'b1) vs_cnt++;
      if (fs_b) begin
        fs_cnt++;
        if (last_fs >= 0) period = i - last_fs;
        last_fs = i;
      end
    end
    checks++;
    if (vs_cnt != 2 * VS_B * HT_B * DIV) begin
      errors++; $display("FAIL vsync_width actual=%0d required=%0d", vs_cnt, 2 * VS_B * HT_B * DIV);
    end
    checks++;
    if (fs_cnt != 2 || period != TOT_B * DIV) begin
      errors++; $display("FAIL frame_period actual=%0d/%0d required=2/%0d", fs_cnt, period, TOT_B * DIV);
    end
  endtask

  task automatic test_div4();
    int phase = int'($urandom_range(0, 3));
    int run = 0, max_run = 0, pulses = 0;
    for (int i = 0; i < 1600; i++) begin
      pix_ce = ((i % 4) == phase);
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL div4_a cyc=%0d actual=%h required=%h", i, obs_a, exp_a);
      end
      checks++;
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL div4_b cyc=%0d actual=%h required=%h", i, obs_b, exp_b);
      end
      if (fs_b) begin
        run++;
        if (run == 1) pulses++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    checks++;
    if (max_run != 1 || pulses < 1) begin
      errors++; $display("FAIL div4_fs actual=width%0d/pulses%0d required=width1/pulses>=1", max_run, pulses);
    end
  endtask

  task automatic test_random_ce();
    for (int i = 0; i < 2000; i++) begin
      pix_ce = 1'($urandom % 2);
      @(negedge clk);
      checks++;
      if (obs_a !== exp_a) begin
        errors++; $display("FAIL rand_a cyc=%0d actual=%h required=%h", i, obs_a, exp_a);
      end
      checks++;
      if (obs_b !== exp_b) begin
        errors++; $display("FAIL rand_b cyc=%0d actual=%h required=%h", i, obs_b, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = int'($urandom_range(50, 300));
    pix_ce = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b1;
    pix_ce = 1'($urandom % 2);
    @(negedge clk);
    checks++;
    if (obs_a !== RST_A) begin
      errors++; $display("FAIL midreset_a actual=%h required=%h", obs_a, RST_A);
    end
    checks++;
    if (obs_b !== exp_b) begin
      errors++; $display("FAIL midreset_b actual=%h required=%h", obs_b, exp_b);
    end
    rst = 1'b0;
    pix_ce = 1'b1;
`ifdef VGA_PIX_DIV4_EN
    repeat (3) @(negedge clk);
`endif
    @(negedge clk);
    checks++;
    if (obs_a !== FIRST_A) begin
      errors++; $display("FAIL midreset_first actual=%h required=%h", obs_a, FIRST_A);
    end
    checks++;
    if (obs_b !== exp_b) begin
      errors++; $display("FAIL midreset_first_b actual=%h required=%h", obs_b, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_div4();
    test_random_ce();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
REQ-005 Parameter SYNC_POL, default 0: asserted level of hsync/vsync (0 = active-low).
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 pix_ce  in  1  pixel clock enable; counters advance only on clk edges where pix_ce=1.
REQ-009 x  out  11  horizontal count, feeds the colour stage x input.
REQ-010 y  out  11  vertical count, feeds the colour stage y input.
REQ-011 enable  out  1  high while (x,y) lies in the active area; feeds the colour stage enable.
REQ-012 hsync, vsync  out  1 each  sync pulses at SYNC_POL level.
REQ-013 frame_start  out  1  single-clk pulse at the start of each frame.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-015 On pix_ce: x increments; x = H_TOTAL-1 wraps to 0 and advances y; y = V_TOTAL-1 with x wrap wraps to 0.
REQ-016 With pix_ce=0, every output except frame_start holds its value.
REQ-017 All outputs are registered and mutually aligned: the same clk edge that loads a new (x,y) also loads that pixel's enable, hsync and vsync.
REQ-018 enable = (x < H_ACTIVE) AND (y < V_ACTIVE).
REQ-019 hsync is at SYNC_POL for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751) and at the inverse otherwise.
REQ-020 vsync is at SYNC_POL for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), for every x on those lines, and at the inverse otherwise.
REQ-021 frame_start is high for exactly one clk, the cycle after the pix_ce edge that loaded (0,0); it is low at all other times.
REQ-022 Counter arithmetic is 11-bit unsigned; compares are against H_TOTAL-1 and V_TOTAL-1, never against overflow.

Reset
REQ-023 On the rst edge: x=H_TOTAL-1 (799), y=V_TOTAL-1 (524), enable=0, hsync=vsync=!SYNC_POL, frame_start=0.
REQ-024 The first pix_ce after reset release loads (0,0), enable=1 and frame_start=1.
REQ-025 rst asserted mid-frame forces the REQ-023 values on the next edge regardless of pix_ce, and rst has priority over pix_ce.

Configuration
REQ-026 Macro VGA_PIX_DIV4_EN: when defined, an internal 2-bit prescaler (reset to 0) generates the pixel enable every 4th clk (when it equals 3), and the pix_ce port is ignored.
REQ-027 When VGA_PIX_DIV4_EN is not defined, pix_ce is used directly and no prescaler exists.

Structure
REQ-028 Package vga_timing_pkg holds the default timing constants (640/16/96/48, 480/10/2/33), the derived totals and the 11-bit coordinate width constant.
REQ-029 Sub-module vga_axis_counter (parameters TOTAL, ACTIVE, SYNC_START, SYNC_LEN; inputs clk, rst, step; outputs count, active, in_sync, wrap) is instantiated once for horizontal and once for vertical, with the horizontal wrap gated into the vertical step.

Verification
REQ-030 rst for 2 clk then pix_ce=1 constantly -> after release the first edge gives x=0, y=0, enable=1 and frame_start=1 for one clk.
REQ-031 Run one line -> enable falls at x=640, hsync goes low for x=656..751 (96 clks), and x=799 wraps to x=0 with y incremented.
REQ-032 Run a full frame -> vsync is low on exactly y=490..491 (1600 pix_ce), and frame_start recurs every 420000 pix_ce.
REQ-033 pix_ce toggling 1-of-4 -> each (x,y) is held 4 clk, frame_start stays 1 clk wide, and the sequence matches the constant-pix_ce run.
REQ-034 rst asserted at x=300, y=200 -> the next edge gives x=799, y=524, enable=0, hsync=vsync=1; the first pix_ce after release gives (0,0).
REQ-035 With VGA_PIX_DIV4_EN defined and pix_ce tied to 0 -> counters advance every 4th clk, with the first advance on the 4th clk after reset release.
